// File: rtl/riscv_regfile_sb.sv
// Integer register file with per-register busy scoreboard for RAW stalls.
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
package riscv_regfile_sb_pkg;
  typedef enum logic {
    RF_READ  = 1'b0,
    RF_WRITE = 1'b1
  } rf_wen_e;
endpackage

module riscv_regfile_sb
  import riscv_regfile_sb_pkg::*;
#(
  parameter int WORD_LENGTH    = 32,
  parameter int ADDR_LENGTH    = 5,
  parameter int NUM_REGS       = 32,
  parameter int NUM_READ_PORTS = 2,
  localparam int CW            = $clog2(NUM_REGS + 1)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  rf_wen_e                                   write_en,
  input  logic [ADDR_LENGTH-1:0]                    write_addr,
  input  logic [WORD_LENGTH-1:0]                    write_data,
  input  logic                                      rsv_en,
  input  logic [ADDR_LENGTH-1:0]                    rsv_addr,
  input  logic [NUM_READ_PORTS-1:0][ADDR_LENGTH-1:0] read_addr,
  output logic [NUM_READ_PORTS-1:0][WORD_LENGTH-1:0] read_data,
  output logic [NUM_READ_PORTS-1:0]                 read_busy,
  output logic [CW-1:0]                             busy_count,
  output logic                                      stray_wb
);

  localparam logic [ADDR_LENGTH:0] NREG = (ADDR_LENGTH + 1)'(NUM_REGS);

  logic [WORD_LENGTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]    busy;
  logic [NUM_REGS-1:0]    busy_nxt;
  logic [CW-1:0]          cnt_nxt;
  logic                   wr_ok;
  logic                   rsv_ok;

  function automatic logic addr_ok(input logic [ADDR_LENGTH-1:0] a);
    return (a != '0) && ({1'b0, a} < NREG);
  endfunction

  assign wr_ok  = (write_en == RF_WRITE) && addr_ok(write_addr);
  assign rsv_ok = rsv_en && addr_ok(rsv_addr);

  // Reserve is applied after the clear so the newer producer keeps the bit.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)
      busy_nxt[write_addr] = 1'b0;
    if (rsv_ok)
      busy_nxt[rsv_addr] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      busy       <= '0;
      busy_count <= '0;
      stray_wb   <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[write_addr] <= write_data;
        if (!busy[write_addr])
          stray_wb <= 1'b1;
      end
      busy       <= busy_nxt;
      busy_count <= cnt_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      read_data[i] = '0;
      read_busy[i] = 1'b0;
      if (addr_ok(read_addr[i])) begin
        read_data[i] = regs[read_addr[i]];
        read_busy[i] = busy[read_addr[i]];
      end
`ifdef RF_BYPASS_EN
      if (wr_ok && (read_addr[i] == write_addr)) begin
        read_data[i] = write_data;
        read_busy[i] = 1'b0;
      end
`endif
    end
  end

endmodule
